eth_frame_writer: RTL and testbench

Parametrised Ethernet frame transmitter feeding an eth_axis_tx-style core. It accepts a frame request (dest MAC, src MAC, ethertype, payload length) and drives the header with a full valid/ready handshake. It then streams the payload from an AXI-Stream input at DATA_WIDTH bits per beat, with tkeep and tlast generation and optional zero-padding to the Ethernet minimum payload. It is the multi-frame, multi-width successor to the single-shot HLS header writer.

---
 rtl/eth_frame_pkg.sv | 15 +
 rtl/eth_lane_mask.sv | 29 ++
 rtl/eth_frame_writer.sv | 146 ++++++++++++++
 tb/tb_eth_frame_writer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_frame_pkg.sv
// Shared constants and FSM encoding for the Ethernet frame writer.
// Holds the header field widths and the minimum padded payload size.
package eth_frame_pkg;

  localparam int MAC_W       = 48;
  localparam int TYPE_W      = 16;
  localparam int MIN_PAYLOAD = 46;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

endpackage

// File: rtl/eth_lane_mask.sv
// Per-lane byte classification for one payload beat (combinational, zero latency).
// Lane i covers byte sent+i: data_sel=real input byte, keep=inside padded frame; last=final beat.
module eth_lane_mask #(
  parameter int KEEP_WIDTH = 1,
  parameter int LEN_WIDTH  = 16
) (
  input  logic [LEN_WIDTH:0]    sent_i,
  input  logic [LEN_WIDTH:0]    data_len_i,
  input  logic [LEN_WIDTH:0]    total_len_i,
  output logic [KEEP_WIDTH-1:0] data_sel_o,
  output logic [KEEP_WIDTH-1:0] keep_o,
  output logic                  last_o
);

  // One extra bit so sent+lane never wraps near the top of the length range.
  localparam int CW = LEN_WIDTH + 2;

  always_comb begin
    data_sel_o = '0;
    keep_o     = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      data_sel_o[i] = ({1'b0, sent_i} + CW'(i)) < {1'b0, data_len_i};
      keep_o[i]     = ({1'b0, sent_i} + CW'(i)) < {1'b0, total_len_i};
    end
  end

  assign last_o = ({1'b0, sent_i} + CW'(KEEP_WIDTH)) >= {1'b0, total_len_i};

endmodule

// File: rtl/eth_frame_writer.sv
// Ethernet frame writer: header handshake, then payload pass-through with tkeep/tlast and zero padding.
// Payload path is zero-latency combinational; stalls on either handshake hold all outputs with nothing consumed.
module eth_frame_writer
  import eth_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16,
  parameter int PAD_ENABLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [47:0]           req_dest_mac,
  input  logic [47:0]           req_src_mac,
  input  logic [15:0]           req_type,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  output logic                  s_eth_hdr_valid,
  input  logic                  s_eth_hdr_ready,
  output logic [47:0]           s_eth_dest_mac,
  output logic [47:0]           s_eth_src_mac,
  output logic [15:0]           s_eth_type,
  output logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  output logic                  s_eth_payload_axis_tvalid,
  input  logic                  s_eth_payload_axis_tready,
  output logic                  s_eth_payload_axis_tlast,
  output logic                  s_eth_payload_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           frames_sent
);

  localparam int LW = LEN_WIDTH + 1;

  state_t            state_q;
  logic [MAC_W-1:0]  dest_q, src_q;
  logic [TYPE_W-1:0] type_q;
  logic [LW-1:0]     data_len_q, total_len_q, sent_q, sent_d;
  logic [31:0]       frames_q, frames_d;

  logic [LW-1:0]         req_len_ext, total_len_d;
  logic [KEEP_WIDTH-1:0] lane_data, lane_keep;
  logic                  lane_last;
  logic                  in_hdr, in_pay, need_in, pay_vld, pay_hs, hdr_hs;

  assign req_len_ext = {1'b0, req_len};
  assign total_len_d = (PAD_ENABLE != 0 && req_len_ext < LW'(MIN_PAYLOAD)) ? LW'(MIN_PAYLOAD)
                                                                          : req_len_ext;
  assign sent_d      = sent_q + LW'(KEEP_WIDTH);
  assign frames_d    = frames_q + 32'd1;

  eth_lane_mask #(
    .KEEP_WIDTH (KEEP_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_lane_mask (
    .sent_i      (sent_q),
    .data_len_i  (data_len_q),
    .total_len_i (total_len_q),
    .data_sel_o  (lane_data),
    .keep_o      (lane_keep),
    .last_o      (lane_last)
  );

  // Every output is masked by rst so the block reads idle during the reset cycle itself.
  assign in_hdr  = !rst && (state_q == HDR);
  assign in_pay  = !rst && (state_q == PAYLOAD);
  assign need_in = sent_q < data_len_q;
  assign pay_vld = in_pay && (need_in ? in_tvalid : 1'b1);
  assign pay_hs  = pay_vld && s_eth_payload_axis_tready;
  assign hdr_hs  = in_hdr && s_eth_hdr_ready;

  assign req_ready       = !rst && (state_q == IDLE);
  assign busy            = !rst && (state_q != IDLE);
  assign s_eth_hdr_valid = in_hdr;
  assign s_eth_dest_mac  = in_hdr ? dest_q : '0;
  assign s_eth_src_mac   = in_hdr ? src_q  : '0;
  assign s_eth_type      = in_hdr ? type_q : '0;
  assign frames_sent     = rst ? '0 : frames_q;
  assign done            = (hdr_hs && total_len_q == '0) || (pay_hs && lane_last);

  assign in_tready                 = in_pay && need_in && s_eth_payload_axis_tready;
  assign s_eth_payload_axis_tvalid = pay_vld;
  assign s_eth_payload_axis_tkeep  = in_pay ? lane_keep : '0;
  assign s_eth_payload_axis_tlast  = in_pay && lane_last;
  assign s_eth_payload_axis_tuser  = 1'b0;

  always_comb begin
    s_eth_payload_axis_tdata = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (in_pay && lane_data[i]) s_eth_payload_axis_tdata[8*i +: 8] = in_tdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      src_q       <= '0;
      type_q      <= '0;
      data_len_q  <= '0;
      total_len_q <= '0;
      sent_q      <= '0;
      frames_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            dest_q      <= req_dest_mac;
            src_q       <= req_src_mac;
            type_q      <= req_type;
            data_len_q  <= req_len_ext;
            total_len_q <= total_len_d;
            sent_q      <= '0;
            state_q     <= HDR;
          end
        end
        HDR: begin
          if (s_eth_hdr_ready) begin
            if (total_len_q != '0) begin
              state_q <= PAYLOAD;
            end else begin
              frames_q <= frames_d;
              state_q  <= IDLE;
            end
          end
        end
        PAYLOAD: begin
          if (pay_hs) begin
            sent_q <= sent_d;
            if (lane_last) begin
              frames_q <= frames_d;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_writer.sv
// Directed bench for eth_frame_writer at three widths (8/no pad, 32/pad, 64/no pad).
module tb_eth_frame_writer;

  typedef struct {
    logic [63:0] din;
    logic [63:0] dout;
    logic [7:0]  keep;
    logic        last;
    logic        in_rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [47:0] req_dest = '0, req_src = '0;
  logic [15:0] req_type = '0, req_len = '0;
  logic [63:0] in_tdata = '0;
  logic        hdr_rdy = 1'b1, pay_rdy = 1'b1;

  logic        r8_valid = 1'b0, i8_valid = 1'b0;
  logic        r8_ready, i8_tready, h8_valid, p8_valid, p8_last, p8_user, b8_busy, d8_done;
  logic [47:0] h8_dest, h8_src;
  logic [15:0] h8_type;
  logic [7:0]  p8_data;
  logic [0:0]  p8_keep;
  logic [31:0] f8_frames;

  logic        r32_valid = 1'b0, i32_valid = 1'b0;
  logic        r32_ready, i32_tready, h32_valid, p32_valid, p32_last, p32_user, b32_busy, d32_done;
  logic [47:0] h32_dest, h32_src;
  logic [15:0] h32_type;
  logic [31:0] p32_data;
  logic [3:0]  p32_keep;
  logic [31:0] f32_frames;

  logic        r64_valid = 1'b0, i64_valid = 1'b0;
  logic        r64_ready, i64_tready, h64_valid, p64_valid, p64_last, p64_user, b64_busy, d64_done;
  logic [47:0] h64_dest, h64_src;
  logic [15:0] h64_type;
  logic [63:0] p64_data;
  logic [7:0]  p64_keep;
  logic [31:0] f64_frames;

  eth_frame_writer #(.DATA_WIDTH(8), .PAD_ENABLE(0)) u8 (
    .clk(clk), .rst(rst), .req_valid(r8_valid), .req_ready(r8_ready),
    .req_dest_mac(req_dest), .req_src_mac(req_src), .req_type(req_type), .req_len(req_len),
    .in_tdata(in_tdata[7:0]), .in_tvalid(i8_valid), .in_tready(i8_tready),
    .s_eth_hdr_valid(h8_valid), .s_eth_hdr_ready(hdr_rdy), .s_eth_dest_mac(h8_dest),
    .s_eth_src_mac(h8_src), .s_eth_type(h8_type), .s_eth_payload_axis_tdata(p8_data),
    .s_eth_payload_axis_tkeep(p8_keep), .s_eth_payload_axis_tvalid(p8_valid),
    .s_eth_payload_axis_tready(pay_rdy), .s_eth_payload_axis_tlast(p8_last),
    .s_eth_payload_axis_tuser(p8_user), .busy(b8_busy), .done(d8_done), .frames_sent(f8_frames));

  eth_frame_writer #(.DATA_WIDTH(32), .PAD_ENABLE(1)) u32 (
    .clk(clk), .rst(rst), .req_valid(r32_valid), .req_ready(r32_ready),
    .req_dest_mac(req_dest), .req_src_mac(req_src), .req_type(req_type), .req_len(req_len),
    .in_tdata(in_tdata[31:0]), .in_tvalid(i32_valid), .in_tready(i32_tready),
    .s_eth_hdr_valid(h32_valid), .s_eth_hdr_ready(hdr_rdy), .s_eth_dest_mac(h32_dest),
    .s_eth_src_mac(h32_src), .s_eth_type(h32_type), .s_eth_payload_axis_tdata(p32_data),
    .s_eth_payload_axis_tkeep(p32_keep), .s_eth_payload_axis_tvalid(p32_valid),
    .s_eth_payload_axis_tready(pay_rdy), .s_eth_payload_axis_tlast(p32_last),
    .s_eth_payload_axis_tuser(p32_user), .busy(b32_busy), .done(d32_done), .frames_sent(f32_frames));

  eth_frame_writer #(.DATA_WIDTH(64), .PAD_ENABLE(0)) u64 (
    .clk(clk), .rst(rst), .req_valid(r64_valid), .req_ready(r64_ready),
    .req_dest_mac(req_dest), .req_src_mac(req_src), .req_type(req_type), .req_len(req_len),
    .in_tdata(in_tdata), .in_tvalid(i64_valid), .in_tready(i64_tready),
    .s_eth_hdr_valid(h64_valid), .s_eth_hdr_ready(hdr_rdy), .s_eth_dest_mac(h64_dest),
    .s_eth_src_mac(h64_src), .s_eth_type(h64_type), .s_eth_payload_axis_tdata(p64_data),
    .s_eth_payload_axis_tkeep(p64_keep), .s_eth_payload_axis_tvalid(p64_valid),
    .s_eth_payload_axis_tready(pay_rdy), .s_eth_payload_axis_tlast(p64_last),
    .s_eth_payload_axis_tuser(p64_user), .busy(b64_busy), .done(d64_done), .frames_sent(f64_frames));

  // Event counters sampled on the active edge: done pulses, header handshakes, in/out beats.
  int dn8 = 0, hh8 = 0, ob8 = 0;
  int dn32 = 0, ib32 = 0, ob32 = 0;
  int dn64 = 0, ib64 = 0, ob64 = 0;
  always @(posedge clk) begin
    if (d8_done) dn8 <= dn8 + 1;
    if (h8_valid && hdr_rdy) hh8 <= hh8 + 1;
    if (p8_valid && pay_rdy) ob8 <= ob8 + 1;
    if (d32_done) dn32 <= dn32 + 1;
    if (i32_valid && i32_tready) ib32 <= ib32 + 1;
    if (p32_valid && pay_rdy) ob32 <= ob32 + 1;
    if (d64_done) dn64 <= dn64 + 1;
    if (i64_valid && i64_tready) ib64 <= ib64 + 1;
    if (p64_valid && pay_rdy) ob64 <= ob64 + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] beat64(input int j);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(j * 8 + i + 1);
    return r;
  endfunction

  vec_t v8[4];
  vec_t v32[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int d0, h0, i0, o0, in_idx, out_idx, cyc, beats;
    logic fin;

    v8[0] = '{64'h11, 64'h11, 8'h01, 1'b0, 1'b1};
    v8[1] = '{64'h22, 64'h22, 8'h01, 1'b0, 1'b1};
    v8[2] = '{64'h33, 64'h33, 8'h01, 1'b0, 1'b1};
    v8[3] = '{64'h44, 64'h44, 8'h01, 1'b1, 1'b1};
    v32[0] = '{64'h44332211, 64'h44332211, 8'h0F, 1'b0, 1'b1};
    v32[1] = '{64'h88776655, 64'h00006655, 8'h0F, 1'b0, 1'b1};
    for (int j = 2; j < 12; j++) v32[j] = '{64'hDEADBEEF, 64'h0, 8'h0F, 1'b0, 1'b0};
    v32[11].keep = 8'h03;
    v32[11].last = 1'b1;

    // Reset: everything reads zero while rst is high.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready8", r8_ready, 1'b0);
    chk("rst_busy32", b32_busy, 1'b0);
    chk("rst_frames64", f64_frames, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_req_ready8", r8_ready, 1'b1);
    chk("idle_hdr_valid8", h8_valid, 1'b0);
    chk("idle_frames8", f8_frames, 32'd0);

    // 8-bit, no pad, 4 bytes.
    d0 = dn8; h0 = hh8;
    @(negedge clk);
    req_dest = 48'h0A0B0C0D0E0F; req_src = 48'h112233445566; req_type = 16'h0800; req_len = 16'd4;
    r8_valid = 1'b1;
    #1 chk("t1_accept", r8_ready, 1'b1);
    @(negedge clk);
    r8_valid = 1'b0;
    #1;
    chk("t1_hdr_valid", h8_valid, 1'b1);
    chk("t1_hdr_dest", h8_dest, 48'h0A0B0C0D0E0F);
    chk("t1_hdr_src", h8_src, 48'h112233445566);
    chk("t1_hdr_type", h8_type, 16'h0800);
    chk("t1_hdr_no_done", d8_done, 1'b0);
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      in_tdata = v8[r].din;
      i8_valid = 1'b1;
      #1;
      chk("t1_tvalid", p8_valid, 1'b1);
      chk("t1_tdata", p8_data, v8[r].dout);
      chk("t1_tkeep", p8_keep, v8[r].keep);
      chk("t1_tlast", p8_last, v8[r].last);
      chk("t1_in_tready", i8_tready, v8[r].in_rdy);
      chk("t1_done", d8_done, v8[r].last);
    end
    @(negedge clk);
    i8_valid = 1'b0;
    #1;
    chk("t1_busy_end", b8_busy, 1'b0);
    chk("t1_frames", f8_frames, 32'd1);
    chk("t1_req_ready_again", r8_ready, 1'b1);
    chk("t1_idle_dest", h8_dest, 48'h0);
    chk("t1_done_count", 64'(dn8 - d0), 64'd1);
    chk("t1_hdr_count", 64'(hh8 - h0), 64'd1);

    // 32-bit, padded: 6 data bytes become 46.
    d0 = dn32; i0 = ib32;
    @(negedge clk);
    req_len = 16'd6;
    r32_valid = 1'b1;
    @(negedge clk);
    r32_valid = 1'b0;
    #1 chk("t2_hdr_valid", h32_valid, 1'b1);
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      in_tdata = v32[r].din;
      i32_valid = 1'b1;
      #1;
      chk("t2_tvalid", p32_valid, 1'b1);
      chk("t2_tdata", p32_data, v32[r].dout);
      chk("t2_tkeep", p32_keep, v32[r].keep);
      chk("t2_tlast", p32_last, v32[r].last);
      chk("t2_in_tready", i32_tready, v32[r].in_rdy);
    end
    @(negedge clk);
    i32_valid = 1'b0;
    #1;
    chk("t2_in_beats", 64'(ib32 - i0), 64'd2);
    chk("t2_done_count", 64'(dn32 - d0), 64'd1);
    chk("t2_frames", f32_frames, 32'd1);
    chk("t2_busy_end", b32_busy, 1'b0);

    // 64-bit: header stalled 10 cycles, then random valid/ready on 64 bytes.
    @(negedge clk);
    req_dest = 48'hFFEEDDCCBBAA; req_src = 48'h020000000001; req_type = 16'h88B5; req_len = 16'd64;
    hdr_rdy = 1'b0;
    r64_valid = 1'b1;
    @(negedge clk);
    r64_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t3_hold_valid", h64_valid, 1'b1);
      chk("t3_hold_dest", h64_dest, 48'hFFEEDDCCBBAA);
      chk("t3_hold_src", h64_src, 48'h020000000001);
      chk("t3_hold_type", h64_type, 16'h88B5);
      chk("t3_no_payload", p64_valid, 1'b0);
      @(negedge clk);
    end
    hdr_rdy = 1'b1;
    #1 chk("t3_hdr_release", h64_valid, 1'b1);
    i0 = ib64; o0 = ob64; d0 = dn64;
    in_idx = 0; out_idx = 0; cyc = 0;
    while (out_idx < 8 && cyc < 300) begin
      @(negedge clk);
      i64_valid = 1'($urandom_range(0, 1));
      pay_rdy   = 1'($urandom_range(0, 1));
      in_tdata  = beat64(in_idx);
      #1;
      if (h64_valid == 1'b0) chk("t4_tvalid_follows", p64_valid, i64_valid);
      if (p64_valid && pay_rdy) begin
        chk("t4_tdata", p64_data, beat64(out_idx));
        chk("t4_tkeep", p64_keep, 8'hFF);
        chk("t4_tlast", p64_last, out_idx == 7);
        out_idx++;
      end
      if (i64_valid && i64_tready) in_idx++;
      cyc++;
    end
    chk("t4_out_beats_seen", 64'(out_idx), 64'd8);
    @(negedge clk);
    i64_valid = 1'b0;
    pay_rdy = 1'b1;
    #1;
    chk("t4_in_beats", 64'(ib64 - i0), 64'd8);
    chk("t4_out_beats", 64'(ob64 - o0), 64'd8);
    chk("t4_done_count", 64'(dn64 - d0), 64'd1);
    chk("t4_frames", f64_frames, 32'd1);
    chk("t4_busy_end", b64_busy, 1'b0);

    // Reset during the third payload beat of a 32-bit frame.
    d0 = dn32;
    @(negedge clk);
    req_len = 16'd20;
    r32_valid = 1'b1;
    @(negedge clk);
    r32_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      in_tdata = 64'h0403020100 + 64'(r);
      i32_valid = 1'b1;
      #1 chk("t5_pre_tvalid", p32_valid, 1'b1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_tvalid", p32_valid, 1'b0);
    chk("t5_rst_req_ready", r32_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    i32_valid = 1'b0;
    #1;
    chk("t5_busy", b32_busy, 1'b0);
    chk("t5_tvalid", p32_valid, 1'b0);
    chk("t5_frames", f32_frames, 32'd0);
    chk("t5_no_done", 64'(dn32 - d0), 64'd0);
    chk("t5_req_ready", r32_ready, 1'b1);

    // Follow-up 2-byte frame pads to 46 bytes and completes.
    i0 = ib32; o0 = ob32;
    @(negedge clk);
    req_len = 16'd2;
    r32_valid = 1'b1;
    @(negedge clk);
    r32_valid = 1'b0;
    beats = 0; fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      in_tdata = 64'h9988BBAA;
      i32_valid = 1'b1;
      #1;
      if (p32_valid && pay_rdy) begin
        if (beats == 0) begin
          chk("t5b_first_data", p32_data, 32'h0000BBAA);
          chk("t5b_first_keep", p32_keep, 4'hF);
        end
        if (p32_last) begin
          chk("t5b_last_keep", p32_keep, 4'h3);
          fin = 1'b1;
        end
        beats++;
      end
    end
    chk("t5b_finished", fin, 1'b1);
    @(negedge clk);
    i32_valid = 1'b0;
    #1;
    chk("t5b_out_beats", 64'(ob32 - o0), 64'd12);
    chk("t5b_in_beats", 64'(ib32 - i0), 64'd1);
    chk("t5b_frames", f32_frames, 32'd1);

    // Header-only frame on the unpadded 8-bit instance.
    o0 = ob8; d0 = dn8;
    @(negedge clk);
    req_len = 16'd0;
    r8_valid = 1'b1;
    @(negedge clk);
    r8_valid = 1'b0;
    #1;
    chk("t6_hdr_valid", h8_valid, 1'b1);
    chk("t6_done_at_hdr", d8_done, 1'b1);
    chk("t6_no_tvalid", p8_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("t6_busy", b8_busy, 1'b0);
    chk("t6_frames", f8_frames, 32'd1);
    chk("t6_no_beats", 64'(ob8 - o0), 64'd0);
    chk("t6_done_count", 64'(dn8 - d0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
